// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and types for the data-memory arbiter.
//   F3_*          RISC-V load/store func3 encodings
//   req_id_e      requester identity (core pipeline / debug loader)
//   lock_state_e  debug ownership state
package dmem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_access_check.sv
// access_check: combinational legality check of one memory request.
//   we       in   store (1) / load (0)
//   func3    in   RISC-V load/store func3
//   addr_lo  in   byte address bits [1:0]
//   legal    out  func3 valid for the direction and address naturally aligned
module access_check
    import dmem_arb_pkg::*;
(
    input  logic       we,
    input  logic [2:0] func3,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (func3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !addr_lo[0];
            F3_W:    legal = (addr_lo == 2'b00);
            // Unsigned variants only exist for loads.
            F3_BU:   legal = !we;
            F3_HU:   legal = !we && !addr_lo[0];
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core MEM
// stage (requester 0) and the debug/loader port (requester 1).
//   clk, rst_n                      clock, async active-low reset
//   core*/dbg* req,we,addr,wdata,func3  request side (held until gnt)
//   core*/dbg* gnt                  combinational accept
//   core*/dbg* rvalid,err,rdata     registered response, one cycle after gnt
//   dbgLock                         keep debug ownership across an RMW
//   memRead/memWrite/memAddr/memWdata/memFunc3  memory request
//   memData                         combinational load data from memory
//
// Lock FSM
//   state    | meaning
//   UNLOCKED | normal priority: core first, dbg after a full core burst
//   LOCKED   | dbg owns memory; core is never granted
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int CORE_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        coreReq,
    input  logic        coreWe,
    input  logic [31:0] coreAddr,
    input  logic [31:0] coreWdata,
    input  logic [2:0]  coreFunc3,
    output logic        coreGnt,
    output logic        coreRvalid,
    output logic        coreErr,
    output logic [31:0] coreRdata,

    input  logic        dbgReq,
    input  logic        dbgWe,
    input  logic [31:0] dbgAddr,
    input  logic [31:0] dbgWdata,
    input  logic [2:0]  dbgFunc3,
    input  logic        dbgLock,
    output logic        dbgGnt,
    output logic        dbgRvalid,
    output logic        dbgErr,
    output logic [31:0] dbgRdata,

    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [2:0]  memFunc3,
    input  logic [31:0] memData
);

    localparam logic [3:0] BURST_MAX = 4'(CORE_BURST_MAX);

    lock_state_e lock_q, lock_d;
    logic [3:0]  burst_q, burst_d;
    logic        core_legal, dbg_legal;
    logic        dbg_first;
    req_id_e     winner;
    logic        sel_we, sel_legal, access_ok;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_func3;
    logic        unused_addr_hi;

    // Memory ignores the address bits above ADDR_W.
    assign unused_addr_hi = ^{coreAddr[31:ADDR_W], dbgAddr[31:ADDR_W]};

    access_check u_chk_core (
        .we      (coreWe),
        .func3   (coreFunc3),
        .addr_lo (coreAddr[1:0]),
        .legal   (core_legal)
    );

    access_check u_chk_dbg (
        .we      (dbgWe),
        .func3   (dbgFunc3),
        .addr_lo (dbgAddr[1:0]),
        .legal   (dbg_legal)
    );

    // Lock FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= UNLOCKED;
        else        lock_q <= lock_d;
    end

    // Lock FSM: next state.
    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            UNLOCKED: if (dbgGnt && dbgLock) lock_d = LOCKED;
            LOCKED:   if (!dbgLock)          lock_d = UNLOCKED;
            default:  lock_d = UNLOCKED;
        endcase
    end

    // Lock FSM outputs: grants. Gated by rst_n so nothing is accepted in reset.
    always_comb begin
        dbg_first = (lock_q == LOCKED) || !coreReq || (burst_q == BURST_MAX);
        dbgGnt    = rst_n && dbgReq && dbg_first;
        coreGnt   = rst_n && coreReq && (lock_q == UNLOCKED) && !dbgGnt;
    end

    // Only core grants that make dbg wait count towards the burst limit.
    always_comb begin
        burst_d = burst_q;
        if (dbgGnt || !dbgReq)
            burst_d = 4'd0;
        else if (coreGnt && (burst_q != BURST_MAX))
            burst_d = burst_q + 4'd1;
    end

    always_comb begin
        winner    = dbgGnt ? REQ_DBG : REQ_CORE;
        sel_we    = (winner == REQ_DBG) ? dbgWe     : coreWe;
        sel_addr  = (winner == REQ_DBG) ? dbgAddr   : coreAddr;
        sel_wdata = (winner == REQ_DBG) ? dbgWdata  : coreWdata;
        sel_func3 = (winner == REQ_DBG) ? dbgFunc3  : coreFunc3;
        sel_legal = (winner == REQ_DBG) ? dbg_legal : core_legal;
        access_ok = (coreGnt || dbgGnt) && sel_legal;

        // Idle and faulted cycles present an all-zero request to memory.
        memRead  = access_ok && !sel_we;
        memWrite = access_ok && sel_we;
        memAddr  = access_ok ? {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W-1:0]} : 32'h0;
        memWdata = access_ok ? sel_wdata : 32'h0;
        memFunc3 = access_ok ? sel_func3 : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q    <= 4'd0;
            coreRvalid <= 1'b0;
            coreErr    <= 1'b0;
            coreRdata  <= 32'h0;
            dbgRvalid  <= 1'b0;
            dbgErr     <= 1'b0;
            dbgRdata   <= 32'h0;
        end else begin
            burst_q    <= burst_d;
            coreRvalid <= coreGnt;
            coreErr    <= coreGnt && !core_legal;
            coreRdata  <= (coreGnt && memRead) ? memData : 32'h0;
            dbgRvalid  <= dbgGnt;
            dbgErr     <= dbgGnt && !dbg_legal;
            dbgRdata   <= (dbgGnt && memRead) ? memData : 32'h0;
        end
    end

endmodule
